// File: rtl/vga_timing_if.sv
// Raster timing bundle driven by vga_timing_gen and consumed by the render path.
// game_clk is only part of the bundle when VGA_GAME_CLK_EN is defined.
interface vga_timing_if;
    logic [9:0] hCount;
    logic [9:0] vCount;
    logic       bright;
    logic       hSync;
    logic       vSync;
    logic       pix_en;
    logic       frame_tick;
`ifdef VGA_GAME_CLK_EN
    logic       game_clk;

    modport master (output hCount, vCount, bright, hSync, vSync, pix_en, frame_tick, game_clk);
    modport slave  (input  hCount, vCount, bright, hSync, vSync, pix_en, frame_tick, game_clk);
`else
    modport master (output hCount, vCount, bright, hSync, vSync, pix_en, frame_tick);
    modport slave  (input  hCount, vCount, bright, hSync, vSync, pix_en, frame_tick);
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing (640x480@60 from 100 MHz) with pixel-enable divider and per-frame tick.
// Optional slow game_clk square wave is built when VGA_GAME_CLK_EN is defined.
module vga_timing_gen #(
    parameter int CLK_DIV     = 4,
    parameter int H_TOTAL     = 800,
    parameter int H_PULSE     = 96,
    parameter int H_VIS_START = 144,
    parameter int H_VIS_END   = 784,
    parameter int V_TOTAL     = 525,
    parameter int V_PULSE     = 2,
    parameter int V_VIS_START = 35,
    parameter int V_VIS_END   = 515
`ifdef VGA_GAME_CLK_EN
    , parameter int GAME_DIV  = 1
`endif
) (
    input  logic          clk,
    input  logic          rst,
    vga_timing_if.master  vga
);

    localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             pix_en;
    logic             frame_tick;
    logic [9:0]       h_cnt;
    logic [9:0]       v_cnt;
    logic             h_wrap;
    logic             v_wrap;

    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);

    // pix_en is registered, so it lands one clk after the divider reaches its last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            pix_en  <= 1'b0;
        end else begin
            pix_en  <= (div_cnt == DIV_LAST);
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt      <= '0;
            v_cnt      <= '0;
            frame_tick <= 1'b0;
        end else begin
            // Tick is set by the same edge that returns the counters to 0,0.
            frame_tick <= pix_en && h_wrap && v_wrap;
            if (pix_en) begin
                if (h_wrap) begin
                    h_cnt <= '0;
                    v_cnt <= v_wrap ? 10'd0 : v_cnt + 10'd1;
                end else begin
                    h_cnt <= h_cnt + 10'd1;
                end
            end
        end
    end

    assign vga.hCount     = h_cnt;
    assign vga.vCount     = v_cnt;
    assign vga.pix_en     = pix_en;
    assign vga.frame_tick = frame_tick;
    assign vga.hSync      = (h_cnt >= 10'(H_PULSE));
    assign vga.vSync      = (v_cnt >= 10'(V_PULSE));
    assign vga.bright     = (h_cnt >= 10'(H_VIS_START)) && (h_cnt < 10'(H_VIS_END)) &&
                            (v_cnt >= 10'(V_VIS_START)) && (v_cnt < 10'(V_VIS_END));

`ifdef VGA_GAME_CLK_EN
    localparam int              FRAME_W    = (GAME_DIV > 1) ? $clog2(GAME_DIV) : 1;
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(GAME_DIV - 1);

    logic [FRAME_W-1:0] frame_cnt;
    logic               game_clk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
            game_clk  <= 1'b0;
        end else if (frame_tick) begin
            if (frame_cnt == FRAME_LAST) begin
                frame_cnt <= '0;
                game_clk  <= ~game_clk;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    assign vga.game_clk = game_clk;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: nominal instance for divider/line timing,
// a scaled-down instance for window decodes, frame wrap, mid-frame reset and game_clk.
module tb_vga_timing_gen;

    // Scaled raster so whole frames fit in a short run: 20x10 pixels, 800 clk per frame.
    localparam int S_DIV   = 4;
    localparam int S_HT    = 20;
    localparam int S_HP    = 3;
    localparam int S_HVS   = 5;
    localparam int S_HVE   = 17;
    localparam int S_VT    = 10;
    localparam int S_VP    = 2;
    localparam int S_VVS   = 3;
    localparam int S_VVE   = 8;
    localparam int S_FRAME = S_DIV * S_HT * S_VT;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_chk = 0;
    int n_bad = 0;

    int first_pix, second_pix, low0, low1, fall1, fall2, wraps;
    int prev_h, prev_v, prev_hs;
    int ticks, vlow, first_tick;
`ifdef VGA_GAME_CLK_EN
    int gpend;
`endif

    vga_timing_if nom_if ();
    vga_timing_if sm_if ();

    vga_timing_gen u_nom (
        .clk (clk),
        .rst (rst),
        .vga (nom_if.master)
    );

    vga_timing_gen #(
        .CLK_DIV     (S_DIV),
        .H_TOTAL     (S_HT),
        .H_PULSE     (S_HP),
        .H_VIS_START (S_HVS),
        .H_VIS_END   (S_HVE),
        .V_TOTAL     (S_VT),
        .V_PULSE     (S_VP),
        .V_VIS_START (S_VVS),
        .V_VIS_END   (S_VVE)
`ifdef VGA_GAME_CLK_EN
        , .GAME_DIV  (2)
`endif
    ) u_small (
        .clk (clk),
        .rst (rst),
        .vga (sm_if.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_small(input int h, input int v, input string tag);
        int found;
        found = 0;
        for (int i = 0; i < 2 * S_FRAME && found == 0; i++) begin
            step();
            if (sm_if.hCount == 10'(h) && sm_if.vCount == 10'(v)) found = 1;
        end
        check({tag, "_reach"}, found, 1);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // 50 edges: counter moves on edges 5,9,..,49 -> 12 pixels.
        repeat (50) step();
        check("pre_rst_h", nom_if.hCount, 12);

        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_h",      nom_if.hCount, 0);
        check("rst_v",      nom_if.vCount, 0);
        check("rst_hsync",  nom_if.hSync, 0);
        check("rst_vsync",  nom_if.vSync, 0);
        check("rst_bright", nom_if.bright, 0);
        check("rst_pix_en", nom_if.pix_en, 0);
        check("rst_tick",   nom_if.frame_tick, 0);
`ifdef VGA_GAME_CLK_EN
        check("rst_game_clk", sm_if.game_clk, 0);
`endif
        @(negedge clk) rst = 1'b0;

        first_pix = 0; second_pix = 0; low0 = 0; low1 = 0;
        fall1 = 0; fall2 = 0; wraps = 0;
        prev_h = 0; prev_v = 0; prev_hs = 0;
        for (int e = 1; e <= 6500; e++) begin
            step();
            if (e == first_pix + 1 && first_pix != 0) check("pix_en_width", nom_if.pix_en, 0);
            if (nom_if.pix_en && first_pix == 0) first_pix = e;
            else if (nom_if.pix_en && second_pix == 0) second_pix = e;
            if (!nom_if.hSync) begin
                if (nom_if.vCount == 10'd0) low0++;
                else if (nom_if.vCount == 10'd1) low1++;
            end
            if (prev_h == 799 && nom_if.hCount == 10'd0) begin
                wraps++;
                if (wraps == 1) begin
                    check("wrap_v_next", nom_if.vCount, 1);
                    check("wrap_v_prev", prev_v, 0);
                end
            end
            if (prev_hs != 0 && !nom_if.hSync) begin
                if (fall1 == 0) fall1 = e;
                else if (fall2 == 0) fall2 = e;
            end
            prev_h  = nom_if.hCount;
            prev_v  = nom_if.vCount;
            prev_hs = nom_if.hSync;
        end
        check("first_pix_edge", first_pix, 4);
        check("pix_period",     second_pix - first_pix, 4);
        check("hsync_low_l0",   low0, 384);
        check("hsync_low_l1",   low1, 384);
        check("line_wraps",     wraps, 2);
        check("first_hs_fall",  fall1, 3201);
        check("line_period",    fall2 - fall1, 3200);

        wait_small(S_HVS, S_VVS - 1, "p_top");
        check("bright_above", sm_if.bright, 0);
        wait_small(S_HVS - 1, S_VVS, "p_left");
        check("bright_left", sm_if.bright, 0);
        wait_small(S_HVS, S_VVS, "p_first");
        check("bright_first", sm_if.bright, 1);
        wait_small(S_HVE - 1, S_VVE - 1, "p_last");
        check("bright_last", sm_if.bright, 1);
        wait_small(S_HVE, S_VVE - 1, "p_right");
        check("bright_right", sm_if.bright, 0);
        wait_small(S_HVS, S_VVE, "p_below");
        check("bright_below", sm_if.bright, 0);

        wait_small(S_HP - 1, 0, "p_hs_lo");
        check("hsync_lo_edge", sm_if.hSync, 0);
        check("vsync_line0",   sm_if.vSync, 0);
        wait_small(S_HP, 0, "p_hs_hi");
        check("hsync_hi_edge", sm_if.hSync, 1);
        wait_small(0, S_VP - 1, "p_vs_lo");
        check("vsync_lo_edge", sm_if.vSync, 0);
        wait_small(0, S_VP, "p_vs_hi");
        check("vsync_hi_edge", sm_if.vSync, 1);

        wait_small(S_HT - 1, S_VT - 1, "p_end");
        wait_small(0, 0, "p_wrap");
        check("wrap_tick", sm_if.frame_tick, 1);
        ticks = 0;
        vlow  = sm_if.vSync ? 0 : 1;
        for (int i = 1; i <= S_FRAME; i++) begin
            step();
            if (i == 1) check("tick_width", sm_if.frame_tick, 0);
            if (i < S_FRAME) begin
                ticks += sm_if.frame_tick ? 1 : 0;
                vlow  += sm_if.vSync ? 0 : 1;
            end else begin
                check("frame_period_tick", sm_if.frame_tick, 1);
                check("frame_period_h", sm_if.hCount, 0);
                check("frame_period_v", sm_if.vCount, 0);
            end
        end
        check("extra_ticks", ticks, 0);
        check("vsync_low",   vlow, S_VP * S_HT * S_DIV);

        wait_small(7, 6, "p_mid");
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_h",    sm_if.hCount, 0);
        check("mid_rst_v",    sm_if.vCount, 0);
        check("mid_rst_pix",  sm_if.pix_en, 0);
        check("mid_rst_tick", sm_if.frame_tick, 0);
        @(negedge clk) rst = 1'b0;

        // Counters first move on edge CLK_DIV+1, so a full frame ends on edge S_FRAME+1.
        ticks = 0;
        first_tick = 0;
`ifdef VGA_GAME_CLK_EN
        gpend = 0;
`endif
        for (int e = 1; e <= 4 * S_FRAME + 20; e++) begin
            step();
`ifdef VGA_GAME_CLK_EN
            if (gpend != 0) begin
                check("game_clk", sm_if.game_clk, (gpend / 2) % 2);
                gpend = 0;
            end
`endif
            if (sm_if.frame_tick) begin
                ticks++;
                if (ticks == 1) first_tick = e;
`ifdef VGA_GAME_CLK_EN
                gpend = ticks;
`endif
            end
        end
        check("post_rst_tick_edge", first_tick, S_FRAME + 1);
        check("post_rst_tick_count", ticks, 4);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
